// File: rtl/sched_pkg.sv
// Shared types for the stage-pipeline issue scheduler: FSM states, requester ids, in-flight tags.
package sched_pkg;
  localparam int TAG_DATA_W  = 8;
  localparam int FAULT_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} sched_state_e;

  typedef enum logic {SRC_UART = 1'b0, SRC_PAT = 1'b1} src_e;

  typedef struct packed {
    src_e                  src;
    logic [TAG_DATA_W-1:0] data;
  } tag_t;
endpackage

// File: rtl/sched_tag_fifo.sv
// In-flight tag FIFO: head visible combinationally, push/pop registered on the same edge.
// Push is ignored when full, pop when empty; a same-cycle pop never frees a slot for that push.
module sched_tag_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/pipe_stage_sched.sv
// Round-robin issue of UART/pattern bytes into the stage pipeline and per-byte return check; stg 1 cycle, result 1 cycle after ret_dv.
// Readies drop when not RUN or tag FIFO full. SCHED_FAULT_HALT_EN: first fault parks the FSM in HALT until rst.
module pipe_stage_sched
  import sched_pkg::*;
#(
  parameter int DATA_W    = TAG_DATA_W,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   glitched_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   uart_dv,
  input  logic [DATA_W-1:0]      uart_data,
  output logic                   uart_ready,
  input  logic                   pat_dv,
  input  logic [DATA_W-1:0]      pat_data,
  output logic                   pat_ready,
  output logic                   stg_dv,
  output logic [DATA_W-1:0]      stg_data,
  input  logic                   ret_dv,
  input  logic [DATA_W-1:0]      ret_data,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  output logic                   res_src,
  output logic                   res_fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  output logic                   busy
);
  sched_state_e state;
  sched_state_e state_nx;
  src_e         last_grant;
  tag_t         push_tag;
  tag_t         head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         issue_ok;
  logic         grant_uart;
  logic         grant_pat;
  logic         push;
  logic         cur_fault;

  sched_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (glitched_clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (ret_dv),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // UART wins a tie unless it took the previous transfer.
  assign issue_ok      = (state == RUN) && !fifo_full;
  assign grant_uart    = uart_dv && (!pat_dv || last_grant == SRC_PAT);
  assign grant_pat     = pat_dv && !grant_uart;
  assign uart_ready    = issue_ok && grant_uart;
  assign pat_ready     = issue_ok && grant_pat;
  assign push          = uart_ready || pat_ready;
  assign push_tag.src  = uart_ready ? SRC_UART : SRC_PAT;
  assign push_tag.data = uart_ready ? uart_data : pat_data;

  // A return with nothing in flight is always a fault.
  assign cur_fault = ret_dv && (fifo_empty || ret_data != head.data);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = fifo_empty ? IDLE : DRAIN;
      DRAIN: begin
        if (enable) state_nx = RUN;
        else if (fifo_empty) state_nx = IDLE;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
`ifdef SCHED_FAULT_HALT_EN
    if (cur_fault) state_nx = HALT;
`endif
  end

  always_ff @(posedge glitched_clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_PAT;
      stg_dv     <= 1'b0;
      stg_data   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_src    <= 1'b0;
      res_fault  <= 1'b0;
      fault_cnt  <= '0;
    end else begin
      state     <= state_nx;
      stg_dv    <= push;
      res_valid <= ret_dv;
      res_fault <= cur_fault;
      if (push) begin
        stg_data   <= push_tag.data;
        last_grant <= push_tag.src;
      end
      if (ret_dv) begin
        res_data <= ret_data;
        res_src  <= fifo_empty ? SRC_UART : head.src;
      end
      if (cur_fault && fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
    end
  end
endmodule
